fp_mul_arbiter: RTL and testbench
=================================

Name: fp_mul_arbiter

Overview:
Shares one single-precision floating-point multiplier (stb/ack handshake on a, b and z) among NUM_REQ requesters, typically the processing elements of one systolic-array row. It arbitrates round-robin, captures the winner's operands, and sequences the multiplier's a/b/z handshakes. It routes the product back to the winning requester and counts completed operations.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
IDW, 2, width of the grant index, equal to clog2(NUM_REQ)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  per-requester operation request
req_a  input  32*NUM_REQ  operand a, requester i at bits [32i+31:32i]
req_b  input  32*NUM_REQ  operand b, same packing
req_ack  output  NUM_REQ  one-cycle pulse when the requester's operands are captured
resp_z  output  32  product for the current granted requester
resp_valid  output  NUM_REQ  one-hot; product available for requester i
resp_ack  input  NUM_REQ  requester i consumes resp_z
mul_a  output  32  to multiplier input_a
mul_a_stb  output  1  to multiplier input_a_stb
mul_a_ack  input  1  from multiplier input_a_ack
mul_b  output  32  to multiplier input_b
mul_b_stb  output  1  to multiplier input_b_stb
mul_b_ack  input  1  from multiplier input_b_ack
mul_z  input  32  from multiplier output_z
mul_z_stb  input  1  from multiplier output_z_stb
mul_z_ack  output  1  to multiplier output_z_ack
busy  output  1  high in every state except IDLE
grant_id  output  IDW  index of the current or last grantee
op_count  output  32  completed operations, wraps at 2^32

Behaviour:
- Reset (async, immediate): state IDLE. All of the following are 0: req_ack, resp_valid, resp_z, mul_a, mul_b, all stb and ack outputs, busy, grant_id, op_count. Round-robin pointer is 0.
- The multiplier is driven from the same rst. A reset mid-operation abandons the operation with no response and no req_ack replay.
- IDLE:
  - If any req_valid bit is set, grant the first set bit at or after the pointer, searching upward with wrap-around.
  - Same edge: latch that requester's a/b into mul_a/mul_b, set grant_id, pulse req_ack[grant] for one cycle, go to SEND.
  - No request: stay in IDLE.
- SEND:
  - mul_a_stb and mul_b_stb assert together.
  - Each stb drops on the edge after its ack is sampled high while the stb is high. Per-operand done flags allow a and b to be acked in either order or in the same cycle.
  - mul_a and mul_b stay stable while their stb is high.
  - When both operands are done, go to WAIT_Z.
- WAIT_Z:
  - When mul_z_stb is sampled high: latch resp_z = mul_z and drive mul_z_ack = 1 for exactly that one cycle (registered, asserted the cycle after stb is seen, deasserted the next).
  - Then go to RESP.
  - mul_z_ack never asserts outside WAIT_Z.
- RESP:
  - resp_valid[grant_id] = 1 and resp_z is held until resp_ack[grant_id] is sampled high. resp_ack on other bits is ignored.
  - On that edge: clear resp_valid, increment op_count, set pointer = (grant_id+1) mod NUM_REQ, go to IDLE.
- Minimum request-to-next-grant overhead is 2 cycles beyond multiplier latency. Back-to-back requests from different requesters are granted on the first IDLE cycle.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 operations.
- A requester keeping req_valid high after req_ack is treated as a new request. Its operands are resampled at the next grant.
- req_valid changing during SEND, WAIT_Z or RESP has no effect on the current operation.
- Operands pass through unmodified. No float arithmetic occurs in this block.

Test Plan:
- Single op: req_valid=0001, a=0x40800000 (4.0), b=0x3F000000 (0.5) -> req_ack[0] pulses once; resp_valid=0001 with resp_z=0x40000000 (2.0); op_count=1 after resp_ack[0].
- Round robin: all four requesters hold req_valid with distinct operands (e.g. requester 2: 0x40400000 * 0x40000000) -> grant order 0,1,2,3,0. Requester 2 receives 0x40C00000 (6.0). resp_valid is always one-hot.
- Pointer wrap: after a grant to requester 3, only requesters 0 and 3 request -> requester 0 is granted next.
- Response backpressure: resp_ack held low for 20 cycles, product 0xBFC00000 * 0x40000000 -> resp_valid and resp_z=0xC0400000 stay stable; no new req_ack; mul_a_stb stays 0.
- Handshake protocol check: stbs drop exactly one edge after the corresponding ack. mul_z_ack is a single-cycle pulse per operation. Operands are stable while stb is high.
- Reset mid-WAIT_Z: assert rst asynchronously -> all outputs are 0 immediately; after release, a new request 0x3F800000 * 0x3F800000 returns 0x3F800000 and op_count=1.

Source files
------------

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one stb/ack floating-point multiplier
// among NUM_REQ requesters; routes each product back to its grantee.
module fp_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ack,
    output logic [31:0]           resp_z,
    output logic [NUM_REQ-1:0]    resp_valid,
    input  logic [NUM_REQ-1:0]    resp_ack,
    output logic [31:0]           mul_a,
    output logic                  mul_a_stb,
    input  logic                  mul_a_ack,
    output logic [31:0]           mul_b,
    output logic                  mul_b_stb,
    input  logic                  mul_b_ack,
    input  logic [31:0]           mul_z,
    input  logic                  mul_z_stb,
    output logic                  mul_z_ack,
    output logic                  busy,
    output logic [IDW-1:0]        grant_id,
    output logic [31:0]           op_count
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_Z, RESP} state_t;

    state_t             state, state_nxt;
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     pick;
    logic [NUM_REQ-1:0] hi_mask;
    logic [NUM_REQ-1:0] masked;
    logic               found;
    logic [31:0]        pick_a, pick_b;
    logic               a_fin, b_fin;
    logic               resp_done;

    // Requests at or above the pointer win; otherwise wrap to the lowest.
    always_comb begin
        hi_mask = '0;
        pick    = '0;
        pick_a  = '0;
        pick_b  = '0;
        for (int i = 0; i < NUM_REQ; i++)
            hi_mask[i] = (IDW'(i) >= rr_ptr);
        masked = req_valid & hi_mask;
        found  = |req_valid;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req_valid[i]) pick = IDW'(i);
        if (|masked)
            for (int i = NUM_REQ - 1; i >= 0; i--)
                if (masked[i]) pick = IDW'(i);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == IDW'(i)) begin
                pick_a = req_a[32*i +: 32];
                pick_b = req_b[32*i +: 32];
            end
        end
    end

    assign a_fin     = !mul_a_stb || mul_a_ack;
    assign b_fin     = !mul_b_stb || mul_b_ack;
    assign resp_done = resp_ack[grant_id];

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (found) state_nxt = SEND;
            SEND:    if (a_fin && b_fin) state_nxt = WAIT_Z;
            WAIT_Z:  if (mul_z_ack) state_nxt = RESP;
            RESP:    if (resp_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ack   <= '0;
            resp_z    <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_a_stb <= 1'b0;
            mul_b_stb <= 1'b0;
            mul_z_ack <= 1'b0;
            grant_id  <= '0;
            op_count  <= '0;
            rr_ptr    <= '0;
        end else begin
            req_ack   <= '0;
            mul_z_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        grant_id  <= pick;
                        mul_a     <= pick_a;
                        mul_b     <= pick_b;
                        mul_a_stb <= 1'b1;
                        mul_b_stb <= 1'b1;
                        req_ack   <= NUM_REQ'(1) << pick;
                    end
                end
                SEND: begin
                    if (mul_a_stb && mul_a_ack) mul_a_stb <= 1'b0;
                    if (mul_b_stb && mul_b_ack) mul_b_stb <= 1'b0;
                end
                WAIT_Z: begin
                    // Second WAIT_Z cycle carries the ack; never re-latch then.
                    if (!mul_z_ack && mul_z_stb) begin
                        resp_z    <= mul_z;
                        mul_z_ack <= 1'b1;
                    end
                end
                RESP: begin
                    if (resp_done) begin
                        op_count <= op_count + 32'd1;
                        rr_ptr   <= (grant_id == IDW'(NUM_REQ - 1)) ?
                                    '0 : grant_id + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign resp_valid = (state == RESP) ? (NUM_REQ'(1) << grant_id) : '0;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter with a table-driven multiplier model
// and a protocol monitor on the a/b/z handshakes.
module tb_fp_mul_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [32*N-1:0] req_a = '0;
    logic [32*N-1:0] req_b = '0;
    logic [N-1:0]    req_ack;
    logic [31:0]     resp_z;
    logic [N-1:0]    resp_valid;
    logic [N-1:0]    resp_ack = '0;
    logic [31:0]     mul_a, mul_b, mul_z;
    logic            mul_a_stb, mul_b_stb, mul_z_ack;
    logic            mul_a_ack, mul_b_ack, mul_z_stb;
    logic            busy;
    logic [1:0]      grant_id;
    logic [31:0]     op_count;

    int total = 0;
    int bad = 0;
    int served = 0;
    int proto_err = 0;
    int z_pulses = 0;
    int gq[$];
    int a_dly = 0;
    int b_dly = 0;
    int lat = 3;

    always #5 clk = ~clk;

    fp_mul_arbiter #(.NUM_REQ(N), .IDW(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ack(req_ack), .resp_z(resp_z),
        .resp_valid(resp_valid), .resp_ack(resp_ack),
        .mul_a(mul_a), .mul_a_stb(mul_a_stb), .mul_a_ack(mul_a_ack),
        .mul_b(mul_b), .mul_b_stb(mul_b_stb), .mul_b_ack(mul_b_ack),
        .mul_z(mul_z), .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack),
        .busy(busy), .grant_id(grant_id), .op_count(op_count)
    );

    // Hand-computed IEEE-754 products for the operand pairs used here.
    function automatic logic [31:0] mul_ref(input logic [31:0] a,
                                            input logic [31:0] b);
        case ({a, b})
            {32'h40800000, 32'h3F000000}: return 32'h40000000;
            {32'h40000000, 32'h40000000}: return 32'h40800000;
            {32'h40400000, 32'h40000000}: return 32'h40C00000;
            {32'h3F800000, 32'h41200000}: return 32'h41200000;
            {32'hBFC00000, 32'h40000000}: return 32'hC0400000;
            {32'h3F800000, 32'h3F800000}: return 32'h3F800000;
            default:                      return 32'h7FC00000;
        endcase
    endfunction

    // Multiplier model: acks each operand after a programmable wait,
    // then presents z after lat cycles until it is acknowledged.
    logic [31:0] la, lb;
    logic        got_a, got_b;
    int          a_wait, b_wait, lat_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a_ack <= 1'b0; mul_b_ack <= 1'b0;
            mul_z_stb <= 1'b0; mul_z <= '0;
            got_a <= 1'b0; got_b <= 1'b0;
            la <= '0; lb <= '0;
            a_wait <= 0; b_wait <= 0; lat_cnt <= 0;
        end else begin
            if (!got_a) begin
                if (mul_a_ack && mul_a_stb) begin
                    la <= mul_a; got_a <= 1'b1;
                    mul_a_ack <= 1'b0; a_wait <= 0;
                end else if (mul_a_stb) begin
                    if (a_wait >= a_dly) mul_a_ack <= 1'b1;
                    a_wait <= a_wait + 1;
                end
            end
            if (!got_b) begin
                if (mul_b_ack && mul_b_stb) begin
                    lb <= mul_b; got_b <= 1'b1;
                    mul_b_ack <= 1'b0; b_wait <= 0;
                end else if (mul_b_stb) begin
                    if (b_wait >= b_dly) mul_b_ack <= 1'b1;
                    b_wait <= b_wait + 1;
                end
            end
            if (got_a && got_b && !mul_z_stb) begin
                if (lat_cnt >= lat - 1) begin
                    mul_z <= mul_ref(la, lb);
                    mul_z_stb <= 1'b1;
                    lat_cnt <= 0;
                end else begin
                    lat_cnt <= lat_cnt + 1;
                end
            end
            if (mul_z_stb && mul_z_ack) begin
                mul_z_stb <= 1'b0;
                got_a <= 1'b0; got_b <= 1'b0;
            end
        end
    end

    // Protocol monitor: stb drop timing, operand stability, z ack pulse.
    logic       p_as, p_aa, p_bs, p_ba, p_za;
    logic [31:0] p_a, p_b;
    logic [N-1:0] p_rq;

    always @(negedge clk) begin
        if (rst) begin
            p_as <= 1'b0; p_aa <= 1'b0; p_bs <= 1'b0; p_ba <= 1'b0;
            p_za <= 1'b0; p_a <= '0; p_b <= '0; p_rq <= '0;
        end else begin
            automatic int e = 0;
            automatic int g = 0;
            if (p_as && p_aa && mul_a_stb) e++;
            if (p_as && !p_aa && !mul_a_stb) e++;
            if (p_bs && p_ba && mul_b_stb) e++;
            if (p_bs && !p_ba && !mul_b_stb) e++;
            if (p_as && mul_a_stb && mul_a !== p_a) e++;
            if (p_bs && mul_b_stb && mul_b !== p_b) e++;
            if (!p_as && !p_bs && mul_a_stb !== mul_b_stb) e++;
            if (mul_z_ack && p_za) e++;
            if (mul_z_ack && resp_valid != '0) e++;
            if (req_ack != '0 && !$onehot(req_ack)) e++;
            if ((req_ack & p_rq) != '0) e++;
            if (resp_valid != '0 && !$onehot(resp_valid)) e++;
            if (e != 0) begin
                $display("FAIL protocol t=%0t violations=%0d want=0",
                         $time, e);
                proto_err <= proto_err + e;
            end
            if (mul_z_ack && !p_za) z_pulses <= z_pulses + 1;
            if (req_ack != '0) begin
                for (int i = 0; i < N; i++) if (req_ack[i]) g = i;
                gq.push_back(g);
            end
            p_as <= mul_a_stb; p_aa <= mul_a_ack;
            p_bs <= mul_b_stb; p_ba <= mul_b_ack;
            p_za <= mul_z_ack; p_a <= mul_a; p_b <= mul_b;
            p_rq <= req_ack;
        end
    end

    task automatic set_op(input int i, input logic [31:0] a,
                          input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic do_reset();
        @(negedge clk); #2 rst = 1'b1;
        @(negedge clk); #2 rst = 1'b0;
        @(negedge clk);
    endtask

    // Waits for a response, acknowledges it, and loads the next request set.
    task automatic serve_one(input logic [N-1:0] nxt, output int idx,
                             output logic [31:0] z, output logic ok);
        for (int i = 0; i < 100 && resp_valid == '0; i++) @(negedge clk);
        ok  = (resp_valid != '0);
        idx = -1;
        z   = resp_z;
        if ($onehot(resp_valid))
            for (int i = 0; i < N; i++) if (resp_valid[i]) idx = i;
        req_valid = nxt;
        if (ok) begin
            resp_ack = resp_valid;
            @(negedge clk);
            resp_ack = '0;
            served++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({req_ack, resp_valid, resp_z, mul_a, mul_b, mul_a_stb,
             mul_b_stb, mul_z_ack, busy, grant_id, op_count} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got ack=%b rv=%b z=%h busy=%b cnt=%h want all 0",
                     req_ack, resp_valid, resp_z, busy, op_count);
        end
        #2 rst = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_idle busy=%b want=0", busy);
        end
    endtask

    task automatic test_single();
        int base;
        base = gq.size();
        set_op(0, 32'h40800000, 32'h3F000000);
        req_valid = 4'b0001;
        for (int i = 0; i < 60 && resp_valid == '0; i++) @(negedge clk);
        total++;
        if (resp_valid !== 4'b0001) begin
            bad++; $display("FAIL single_rv got=%b want=0001", resp_valid);
        end
        total++;
        if (resp_z !== 32'h40000000) begin
            bad++; $display("FAIL single_z got=%h want=40000000", resp_z);
        end
        total++;
        if (op_count !== 32'd0) begin
            bad++; $display("FAIL single_cnt_pre got=%0d want=0", op_count);
        end
        resp_ack = 4'b0001;
        @(negedge clk);
        resp_ack = '0;
        req_valid = '0;
        served++;
        @(negedge clk);
        total++;
        if (op_count !== 32'd1 || resp_valid !== '0) begin
            bad++;
            $display("FAIL single_done cnt=%0d rv=%b want cnt=1 rv=0000",
                     op_count, resp_valid);
        end
        total++;
        if (gq.size() - base !== 1 || gq[base] !== 0) begin
            bad++;
            $display("FAIL single_req_ack pulses=%0d want=1 grantee 0",
                     gq.size() - base);
        end
    endtask

    task automatic test_round_robin();
        int          ord[5] = '{0, 1, 2, 3, 0};
        logic [31:0] zx[4] = '{32'h40000000, 32'h40800000,
                               32'h40C00000, 32'h41200000};
        int          idx;
        logic [31:0] z;
        logic        ok;
        do_reset();
        set_op(0, 32'h40800000, 32'h3F000000);
        set_op(1, 32'h40000000, 32'h40000000);
        set_op(2, 32'h40400000, 32'h40000000);
        set_op(3, 32'h3F800000, 32'h41200000);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            serve_one((k == 4) ? 4'b0000 : 4'b1111, idx, z, ok);
            total++;
            if (!ok || idx !== ord[k] || z !== zx[ord[k]]) begin
                bad++;
                $display("FAIL rr_op%0d ok=%b idx=%0d z=%h want idx=%0d z=%h",
                         k, ok, idx, z, ord[k], zx[ord[k]]);
            end
        end
        @(negedge clk);
        total++;
        if (op_count !== 32'd5) begin
            bad++; $display("FAIL rr_count got=%0d want=5", op_count);
        end
    endtask

    task automatic test_ptr_wrap();
        int          ord[3] = '{3, 0, 3};
        logic [N-1:0] nx[3] = '{4'b1001, 4'b1001, 4'b0000};
        int          idx;
        logic [31:0] z;
        logic        ok;
        req_valid = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            serve_one(nx[k], idx, z, ok);
            total++;
            if (!ok || idx !== ord[k]) begin
                bad++;
                $display("FAIL wrap_op%0d ok=%b idx=%0d want=%0d",
                         k, ok, idx, ord[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        int          idx;
        logic [31:0] z;
        logic        ok;
        int          errs;
        set_op(2, 32'hBFC00000, 32'h40000000);
        req_valid = 4'b0100;
        for (int i = 0; i < 60 && resp_valid == '0; i++) @(negedge clk);
        req_valid = 4'b1111;
        errs = 0;
        for (int c = 0; c < 20; c++) begin
            if (resp_valid !== 4'b0100 || resp_z !== 32'hC0400000 ||
                req_ack !== '0 || mul_a_stb !== 1'b0) errs++;
            @(negedge clk);
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL bp_hold bad_cycles=%0d rv=%b z=%h want 0 rv=0100 z=c0400000",
                     errs, resp_valid, resp_z);
        end
        resp_ack = 4'b0111;
        req_valid = 4'b1011;
        @(negedge clk);
        resp_ack = '0;
        served++;
        total++;
        if (busy !== 1'b0 || req_ack !== '0) begin
            bad++;
            $display("FAIL bp_idle busy=%b ack=%b want 0 0000", busy, req_ack);
        end
        @(negedge clk);
        total++;
        if (req_ack !== 4'b1000) begin
            bad++; $display("FAIL b2b_grant got=%b want=1000", req_ack);
        end
        serve_one(4'b0000, idx, z, ok);
        total++;
        if (!ok || idx !== 3 || z !== 32'h41200000) begin
            bad++;
            $display("FAIL b2b_resp ok=%b idx=%0d z=%h want 3 41200000",
                     ok, idx, z);
        end
    endtask

    task automatic test_handshake();
        int          ad[3] = '{3, 0, 2};
        int          bd[3] = '{0, 2, 2};
        int          idx;
        logic [31:0] z;
        logic        ok;
        set_op(1, 32'h40000000, 32'h40000000);
        for (int k = 0; k < 3; k++) begin
            a_dly = ad[k];
            b_dly = bd[k];
            req_valid = 4'b0010;
            serve_one(4'b0000, idx, z, ok);
            total++;
            if (!ok || idx !== 1 || z !== 32'h40800000) begin
                bad++;
                $display("FAIL hs_op%0d ok=%b idx=%0d z=%h want 1 40800000",
                         k, ok, idx, z);
            end
        end
        a_dly = 0;
        b_dly = 0;
    endtask

    task automatic test_reset_mid();
        int          idx;
        logic [31:0] z;
        logic        ok;
        lat = 10;
        set_op(0, 32'h3F800000, 32'h3F800000);
        req_valid = 4'b0001;
        @(negedge clk);
        for (int i = 0; i < 40 && !(busy && !mul_a_stb && !mul_b_stb); i++)
            @(negedge clk);
        total++;
        if (!(busy && !mul_a_stb && !mul_b_stb && !mul_z_stb)) begin
            bad++; $display("FAIL rm_reach_waitz busy=%b want=1", busy);
        end
        req_valid = '0;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({req_ack, resp_valid, resp_z, mul_a, mul_b, mul_a_stb,
             mul_b_stb, mul_z_ack, busy, grant_id, op_count} !== '0) begin
            bad++;
            $display("FAIL rm_async busy=%b a=%h cnt=%0d stb=%b want all 0",
                     busy, mul_a, op_count, mul_a_stb);
        end
        @(negedge clk);
        #2 rst = 1'b0;
        lat = 3;
        @(negedge clk);
        req_valid = 4'b0001;
        serve_one(4'b0000, idx, z, ok);
        total++;
        if (!ok || idx !== 0 || z !== 32'h3F800000) begin
            bad++;
            $display("FAIL rm_new ok=%b idx=%0d z=%h want 0 3f800000",
                     ok, idx, z);
        end
        total++;
        if (op_count !== 32'd1) begin
            bad++; $display("FAIL rm_count got=%0d want=1", op_count);
        end
    endtask

    task automatic test_protocol();
        @(negedge clk);
        total++;
        if (proto_err !== 0) begin
            bad++; $display("FAIL proto_total got=%0d want=0", proto_err);
        end
        total++;
        if (z_pulses !== served) begin
            bad++;
            $display("FAIL z_ack_pulses got=%0d want=%0d", z_pulses, served);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_ptr_wrap();
        test_backpressure();
        test_handshake();
        test_reset_mid();
        test_protocol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
